// File: rtl/dcm_supervisor_if.sv
// dcm_supervisor_if: DCM control, lock status and reset outputs
// of the clock-stage supervisor.
interface dcm_supervisor_if;
  logic       ext_reset;
  logic       dcm1_locked;
  logic       dcm2_locked;
  logic       dcm1_rst;
  logic       dcm2_rst;
  logic       ddr_clk_ok;
  logic       sys_reset;
  logic [3:0] retry_count;
  logic       fail;

  modport master (
    input  ext_reset,
    input  dcm1_locked,
    input  dcm2_locked,
    output dcm1_rst,
    output dcm2_rst,
    output ddr_clk_ok,
    output sys_reset,
    output retry_count,
    output fail
  );

  modport slave (
    output ext_reset,
    output dcm1_locked,
    output dcm2_locked,
    input  dcm1_rst,
    input  dcm2_rst,
    input  ddr_clk_ok,
    input  sys_reset,
    input  retry_count,
    input  fail
  );
endinterface

// File: rtl/dcm_supervisor.sv
// dcm_supervisor: reset/lock sequencer for two cascaded DCM stages.
// Define DCM_SUPERVISOR_RETRY_LIMIT_EN to stop in FAIL after MAX_RETRIES.
module dcm_supervisor #(
  parameter int RST_CYCLES   = 4,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STRETCH      = 16777215,
  parameter int MAX_RETRIES  = 7
) (
  input  logic clk,
  input  logic reset_n,
  dcm_supervisor_if.master io
);

  localparam int M01 =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC = (M01 > STRETCH) ? M01 : STRETCH;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

`ifdef DCM_SUPERVISOR_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_RST1,
    S_WAIT1,
    S_RST2,
    S_WAIT2,
    S_STRETCH,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    retry_q;
  logic [3:0]    retry_nxt;
  logic [3:0]    retry_inc;

  // bit 0: dcm1_locked, bit 1: dcm2_locked, bit 2: ext_reset
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic       l1;
  logic       l2;
  logic       er;

  logic rst_done;
  logic str_done;
  logic tmo;
  logic exhausted;

  logic dcm1_rst_q;
  logic dcm2_rst_q;
  logic ddr_ok_q;
  logic sys_reset_q;

  assign l1 = sync2[0];
  assign l2 = sync2[1];
  assign er = sync2[2];

  assign rst_done  = (cnt == CW'(RST_CYCLES - 1));
  assign str_done  = (cnt == CW'(STRETCH - 1));
  assign tmo       = (cnt == CW'(LOCK_TIMEOUT - 1));
  assign retry_inc = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
  assign exhausted = LIMIT_EN &&
                     (int'(retry_q) >= MAX_RETRIES);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    retry_nxt = retry_q;
    unique case (state)
      S_RST1: begin
        if (rst_done) state_nxt = S_WAIT1;
      end
      S_WAIT1: begin
        if (l1) begin
          state_nxt = S_RST2;
        end else if (tmo) begin
          retry_nxt = retry_inc;
          state_nxt = exhausted ? S_FAIL : S_RST1;
        end
      end
      S_RST2: begin
        if (!l1) state_nxt = S_RST1;
        else if (rst_done) state_nxt = S_WAIT2;
      end
      S_WAIT2: begin
        if (!l1) begin
          state_nxt = S_RST1;
        end else if (l2) begin
          state_nxt = S_STRETCH;
        end else if (tmo) begin
          retry_nxt = retry_inc;
          state_nxt = exhausted ? S_FAIL : S_RST2;
        end
      end
      S_STRETCH: begin
        if (!l1) state_nxt = S_RST1;
        else if (!l2) state_nxt = S_RST2;
        else if (er) cnt_nxt = '0;
        else if (str_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt;
        if (!l1) state_nxt = S_RST1;
        else if (!l2) state_nxt = S_RST2;
        else if (er) state_nxt = S_STRETCH;
      end
      S_FAIL: begin
        cnt_nxt = cnt;
      end
      default: begin
        state_nxt = S_RST1;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs decode the next state so they move with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      state       <= S_RST1;
      cnt         <= '0;
      retry_q     <= '0;
      dcm1_rst_q  <= 1'b1;
      dcm2_rst_q  <= 1'b1;
      ddr_ok_q    <= 1'b0;
      sys_reset_q <= 1'b1;
    end else begin
      sync1 <= {io.ext_reset, io.dcm2_locked, io.dcm1_locked};
      sync2 <= sync1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_q     <= retry_nxt;
      dcm1_rst_q  <= state_nxt inside {S_RST1, S_FAIL};
      dcm2_rst_q  <= state_nxt inside
                     {S_RST1, S_WAIT1, S_RST2, S_FAIL};
      ddr_ok_q    <= state_nxt inside {S_STRETCH, S_RUN};
      sys_reset_q <= (state_nxt != S_RUN);
    end
  end

`ifdef DCM_SUPERVISOR_RETRY_LIMIT_EN
  logic fail_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fail_q <= 1'b0;
    else fail_q <= (state_nxt == S_FAIL);
  end

  assign io.fail = fail_q;
`else
  assign io.fail = 1'b0;
`endif

  assign io.dcm1_rst    = dcm1_rst_q;
  assign io.dcm2_rst    = dcm2_rst_q;
  assign io.ddr_clk_ok  = ddr_ok_q;
  assign io.sys_reset   = sys_reset_q;
  assign io.retry_count = retry_q;

endmodule
